addr_gen_pipe: RTL and testbench

Parametrised, handshaked successor to the LC-3b address adder. Computes the effective address (EA) as ADDR1 (PC or BaseR) plus a sign-extended IR offset, with an optional left shift of the offset, and registers the result. It then emits a burst of 1..MAX_BURST sequential addresses, each carrying last, misalignment and wrap flags. It sits between decode/microsequencer and the memory interface, and lets multi-word accesses run without microcode loops.

---
 rtl/lc3b_agu_pkg.sv | 18 +
 rtl/addr_gen_ea.sv | 42 ++++
 rtl/addr_gen_pipe.sv | 117 +++++++++++
 tb/tb_addr_gen_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_agu_pkg.sv
// Shared encodings for the LC-3b address generation unit: ADDR1/ADDR2 mux selects
// and the burst FSM state type.
package lc3b_agu_pkg;

    localparam logic ADDR1_PC    = 1'b0;
    localparam logic ADDR1_BASER = 1'b1;

    localparam logic [1:0] ADDR2_ZERO       = 2'd0;
    localparam logic [1:0] ADDR2_OFFSET6    = 2'd1;
    localparam logic [1:0] ADDR2_PCOFFSET9  = 2'd2;
    localparam logic [1:0] ADDR2_PCOFFSET11 = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/addr_gen_ea.sv
// Combinational effective-address adder: ADDR1 plus the sign-extended, optionally
// left-shifted IR offset, with the carry out of the WIDTH-bit sum.
module addr_gen_ea
    import lc3b_agu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             addr1_sel,
    input  logic [1:0]       addr2_sel,
    input  logic             lshft,
    input  logic [WIDTH-1:0] ir,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] sr1,
    output logic [WIDTH-1:0] ea,
    output logic             carry
);

    logic [WIDTH-1:0] addr1;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] offset_sh;
    logic [WIDTH:0]   sum;
    logic             unused_ir_hi;

    // Only the low 11 IR bits ever feed an offset.
    assign unused_ir_hi = ^ir[WIDTH-1:11];

    always_comb begin
        addr1 = (addr1_sel == ADDR1_BASER) ? sr1 : pc;
        case (addr2_sel)
            ADDR2_OFFSET6:    offset = {{(WIDTH-6){ir[5]}}, ir[5:0]};
            ADDR2_PCOFFSET9:  offset = {{(WIDTH-9){ir[8]}}, ir[8:0]};
            ADDR2_PCOFFSET11: offset = {{(WIDTH-11){ir[10]}}, ir[10:0]};
            default:          offset = '0;
        endcase
        offset_sh = lshft ? {offset[WIDTH-2:0], 1'b0} : offset;
        sum       = {1'b0, addr1} + {1'b0, offset_sh};
    end

    assign ea    = sum[WIDTH-1:0];
    assign carry = sum[WIDTH];

endmodule

// File: rtl/addr_gen_pipe.sv
// Handshaked address generator: registers the EA on accept, then streams a burst of
// 1..MAX_BURST sequential beat addresses with last/misaligned/wrap flags.
//
//   state | meaning
//   IDLE  | no beat presented, ready for a request
//   BURST | a beat is on out_addr; cnt_q counts beats remaining after it
module addr_gen_pipe
    import lc3b_agu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             addr1_sel,
    input  logic [1:0]       addr2_sel,
    input  logic             lshft,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [WIDTH-1:0] ir,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] sr1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_addr,
    output logic             out_last,
    output logic             out_misaligned,
    output logic             out_wrap
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ea;
    logic             ea_carry;
    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] cnt_q;
    logic             stride_q;
    logic [WIDTH:0]   next_addr;
    logic             fire_last;
    logic             accept;
    logic             beat;

    addr_gen_ea #(.WIDTH(WIDTH)) u_ea (
        .addr1_sel (addr1_sel),
        .addr2_sel (addr2_sel),
        .lshft     (lshft),
        .ir        (ir),
        .pc        (pc),
        .sr1       (sr1),
        .ea        (ea),
        .carry     (ea_carry)
    );

    always_comb begin
        n_eff = burst_len;
        if (burst_len == '0)
            n_eff = ONE;
        else if (burst_len > MAX_N)
            n_eff = MAX_N;
    end

    assign out_valid = (state_q == BURST);
    assign fire_last = out_valid && out_ready && out_last;
    assign req_ready = !rst && ((state_q == IDLE) || fire_last);
    assign accept    = req_valid && req_ready;
    assign beat      = out_valid && out_ready && !out_last;

    // stride_q selects +2 (lshft request) or +1; carry into bit WIDTH marks a wrap.
    assign next_addr = {1'b0, out_addr} + {{(WIDTH-1){1'b0}}, stride_q, !stride_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BURST;
            BURST:   if (fire_last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr       <= '0;
            out_last       <= 1'b0;
            out_misaligned <= 1'b0;
            out_wrap       <= 1'b0;
            cnt_q          <= '0;
            stride_q       <= 1'b0;
        end else if (accept) begin
            out_addr       <= ea;
            out_last       <= (n_eff == ONE);
            out_misaligned <= lshft & ea[0];
            out_wrap       <= ea_carry;
            cnt_q          <= n_eff - ONE;
            stride_q       <= lshft;
        end else if (beat) begin
            out_addr       <= next_addr[WIDTH-1:0];
            out_last       <= (cnt_q == ONE);
            out_misaligned <= stride_q & next_addr[0];
            out_wrap       <= out_wrap | next_addr[WIDTH];
            cnt_q          <= cnt_q - ONE;
        end else if (fire_last) begin
            out_last       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addr_gen_pipe.sv
// Randomised bench for addr_gen_pipe: a queue of expected beats per accepted request
// is built from the address rules and compared on every cycle a beat is presented.
module tb_addr_gen_pipe;
    import lc3b_agu_pkg::*;

    localparam int W  = 16;
    localparam int MB = 4;
    localparam int CW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          addr1_sel = 1'b0;
    logic [1:0]    addr2_sel = 2'd0;
    logic          lshft = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic [W-1:0]  ir = '0;
    logic [W-1:0]  pc = '0;
    logic [W-1:0]  sr1 = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_addr;
    logic          out_last;
    logic          out_misaligned;
    logic          out_wrap;

    int n_checks = 0;
    int n_fail   = 0;
    bit rdy_rand = 1'b0;
    bit rst_rand = 1'b0;
    bit exp_rst  = 1'b0;

    typedef struct {
        logic [W-1:0] addr;
        logic         last;
        logic         mis;
        logic         wrap;
    } beat_t;

    beat_t exp_q[$];

    addr_gen_pipe #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .addr1_sel      (addr1_sel),
        .addr2_sel      (addr2_sel),
        .lshft          (lshft),
        .burst_len      (burst_len),
        .ir             (ir),
        .pc             (pc),
        .sr1            (sr1),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr),
        .out_last       (out_last),
        .out_misaligned (out_misaligned),
        .out_wrap       (out_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expand the request currently on the inputs into its full list of beats.
    function automatic void push_req();
        longint mask = (longint'(1) << W) - 1;
        longint a1, off, sum, a;
        int     n, stride;
        bit     w;
        a1 = addr1_sel ? longint'(sr1) : longint'(pc);
        case (addr2_sel)
            2'd1:    off = longint'($signed(ir[5:0]));
            2'd2:    off = longint'($signed(ir[8:0]));
            2'd3:    off = longint'($signed(ir[10:0]));
            default: off = 0;
        endcase
        off    = (lshft ? off * 2 : off) & mask;
        sum    = a1 + off;
        w      = (sum > mask);
        a      = sum & mask;
        n      = (burst_len == 0) ? 1 : ((int'(burst_len) > MB) ? MB : int'(burst_len));
        stride = lshft ? 2 : 1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: W'(a), last: (i == n - 1), mis: (lshft && (a & 1) != 0), wrap: w});
            a = a + stride;
            if (a > mask) begin
                w = 1'b1;
                a = a & mask;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (exp_rst) begin
            chk("rst_addr", 32'(out_addr), 32'd0);
            chk("rst_flags", {29'd0, out_last, out_misaligned, out_wrap}, 32'd0);
        end
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("req_ready", 32'(req_ready),
            32'(!rst && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready))));
        if (exp_q.size() != 0 && out_valid) begin
            chk("beat_addr", 32'(out_addr), 32'(exp_q[0].addr));
            chk("beat_last", 32'(out_last), 32'(exp_q[0].last));
            chk("beat_mis", 32'(out_misaligned), 32'(exp_q[0].mis));
            chk("beat_wrap", 32'(out_wrap), 32'(exp_q[0].wrap));
        end
        exp_rst = rst;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() != 0)
                void'(exp_q.pop_front());
            if (req_valid && req_ready)
                push_req();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        if (rst_rand) rst = ($urandom_range(0, 80) == 0);
    endtask

    task automatic send(input bit a1, input logic [1:0] a2, input bit ls, input logic [CW-1:0] bl,
                        input logic [W-1:0] irv, input logic [W-1:0] pcv, input logic [W-1:0] srv);
        bit acc = 1'b0;
        addr1_sel = a1;
        addr2_sel = a2;
        lshft     = ls;
        burst_len = bl;
        ir        = irv;
        pc        = pcv;
        sr1       = srv;
        req_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = req_ready;
            tick();
        end
        if (!acc) chk("req_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        send(ADDR1_PC, ADDR2_OFFSET6, 1'b0, 3'd1, 16'h1111, 16'd5, 16'h0);
        repeat (2) tick();
        send(ADDR1_PC, ADDR2_PCOFFSET9, 1'b0, 3'd0, 16'hFF01, 16'd256, 16'h0);
        repeat (2) tick();
        send(ADDR1_BASER, ADDR2_PCOFFSET11, 1'b1, 3'd3, 16'hFFFF, 16'h0, 16'h0040);
        repeat (4) tick();

        // Same burst with a stall on beat 2.
        send(ADDR1_BASER, ADDR2_PCOFFSET11, 1'b1, 3'd3, 16'hFFFF, 16'h0, 16'h0040);
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (3) tick();

        send(ADDR1_BASER, ADDR2_ZERO, 1'b1, 3'd2, 16'h0, 16'h0, 16'hFFFE);
        repeat (3) tick();
        send(ADDR1_BASER, ADDR2_ZERO, 1'b1, 3'd1, 16'h0, 16'h0, 16'h0041);
        repeat (2) tick();

        // Back-to-back: second request waits on req_valid through the first burst.
        send(ADDR1_PC, ADDR2_ZERO, 1'b0, 3'd2, 16'h0, 16'h0300, 16'h0);
        send(ADDR1_PC, ADDR2_PCOFFSET11, 1'b0, 3'd1, 16'hFF9C, 16'd200, 16'h0);
        repeat (2) tick();

        // Reset on beat 2 of a 4-beat burst.
        send(ADDR1_PC, ADDR2_ZERO, 1'b0, 3'd4, 16'h0, 16'h1000, 16'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Burst length clamp and random traffic with stalls and occasional resets.
        send(ADDR1_PC, ADDR2_ZERO, 1'b0, 3'd7, 16'h0, 16'h2000, 16'h0);
        rdy_rand = 1'b1;
        rst_rand = 1'b1;
        repeat (400) begin
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 CW'($urandom_range(0, 7)), W'($urandom),
                 ($urandom_range(0, 3) == 0) ? (16'hFFF0 | W'($urandom_range(0, 15))) : W'($urandom),
                 ($urandom_range(0, 3) == 0) ? (16'hFFF0 | W'($urandom_range(0, 15))) : W'($urandom));
            if ($urandom_range(0, 4) == 0) tick();
        end
        rst_rand  = 1'b0;
        rst       = 1'b0;
        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
